// File: rtl/stage3_pool_scheduler.sv
// Frame sequencer for the stage-3 ReLU -> 2x2 max-pool path.
// Tracks raster position of accepted pixels, strobes at each complete
// stride-2 window, drains the pool pipeline and reports frame completion.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for i_start; counters cleared on start
// S_RUN   | accepting pixels in raster order
// S_FLUSH | draining PIPE_LAT cycles of pool datapath latency
// S_DONE  | one-cycle frame-done pulse, then back to idle
module stage3_pool_scheduler #(
  parameter int IMG_W    = 12,
  parameter int IMG_H    = 12,
  parameter int PIPE_LAT = 2,
  parameter int CNT_BW   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_in_valid,
  output logic              o_busy,
  output logic              o_pool_en,
  output logic [CNT_BW-1:0] o_out_row,
  output logic [CNT_BW-1:0] o_out_col,
  output logic [CNT_BW-1:0] o_pool_cnt,
  output logic              o_frame_done,
  output logic              o_err_drop
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  localparam int FW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [FW-1:0]     FLUSH_LOAD   = FW'(PIPE_LAT - 1);
  localparam logic [CNT_BW-1:0] COL_LAST     = CNT_BW'(IMG_W - 1);
  localparam logic [CNT_BW-1:0] ROW_LAST     = CNT_BW'(IMG_H - 1);
  // Highest row/col that still closes a full window (floor semantics on odd dims)
  localparam logic [CNT_BW-1:0] COL_POOL_MAX = CNT_BW'(2 * (IMG_W / 2) - 1);
  localparam logic [CNT_BW-1:0] ROW_POOL_MAX = CNT_BW'(2 * (IMG_H / 2) - 1);

  state_t            r_state, w_next;
  logic [CNT_BW-1:0] r_row, r_col;
  logic [FW-1:0]     r_flush_cnt;
  logic              r_pool_en, r_frame_done, r_err_drop;
  logic [CNT_BW-1:0] r_out_row, r_out_col, r_pool_cnt;

  logic w_start, w_accept, w_last, w_window, w_flush_end;

  assign w_start     = (r_state == S_IDLE) && i_start;
  assign w_accept    = (r_state == S_RUN) && i_in_valid;
  assign w_last      = w_accept && (r_row == ROW_LAST) && (r_col == COL_LAST);
  assign w_flush_end = (r_state == S_FLUSH) && (r_flush_cnt == '0);
  assign w_window    = w_accept && r_row[0] && r_col[0] &&
                       (r_row <= ROW_POOL_MAX) && (r_col <= COL_POOL_MAX);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_FLUSH;
      S_FLUSH: if (w_flush_end) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Raster position of the next pixel to be accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_start) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_accept) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Window-complete strobe with pooled coordinates and strobe count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pool_en  <= 1'b0;
      r_out_row  <= '0;
      r_out_col  <= '0;
      r_pool_cnt <= '0;
    end else begin
      r_pool_en <= w_window;
      if (w_window) begin
        r_out_row <= r_row >> 1;
        r_out_col <= r_col >> 1;
      end
      if (w_start)       r_pool_cnt <= '0;
      else if (w_window) r_pool_cnt <= r_pool_cnt + 1'b1;
    end
  end

  // Flush down-counter: held at its load value while running, counts down in FLUSH
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                        r_flush_cnt <= '0;
    else if (r_state == S_RUN)                        r_flush_cnt <= FLUSH_LOAD;
    else if (r_state == S_FLUSH && r_flush_cnt != '0) r_flush_cnt <= r_flush_cnt - 1'b1;
  end

  // Frame-done pulse lands in the DONE cycle; drop flag is sticky until next start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_done <= 1'b0;
      r_err_drop   <= 1'b0;
    end else begin
      r_frame_done <= w_flush_end;
      if (i_in_valid && r_state != S_RUN) r_err_drop <= 1'b1;
      else if (w_start)                   r_err_drop <= 1'b0;
    end
  end

  assign o_busy       = (r_state == S_RUN) || (r_state == S_FLUSH);
  assign o_pool_en    = r_pool_en;
  assign o_out_row    = r_out_row;
  assign o_out_col    = r_out_col;
  assign o_pool_cnt   = r_pool_cnt;
  assign o_frame_done = r_frame_done;
  assign o_err_drop   = r_err_drop;

endmodule
